// File: rtl/usb2_in_sched.sv
`default_nettype none
// ============================================================================
// Module   : usb2_in_sched
// Purpose  : USB2 IN-token responder: NAK, DATA0/1 streaming, handshake wait.
// Revision : 1.0
// ============================================================================
module usb2_in_sched #(
   parameter logic [3:0] MAX_ENDP   = 4'd2,
   parameter logic [9:0] HS_TIMEOUT = 10'd200
) (
   input  logic       phy_clk,
   input  logic       reset_n,
   input  logic       token_in,
   input  logic [3:0] token_endp,
   output logic [3:0] sel_endp,
   output logic [8:0] buf_out_addr,
   input  logic [7:0] buf_out_q,
   input  logic [9:0] buf_out_len,
   input  logic       buf_out_hasdata,
   output logic       buf_out_arm,
   input  logic       buf_out_arm_ack,
   input  logic [1:0] data_toggle,
   output logic       data_toggle_act,
   output logic       tx_start,
   output logic [3:0] tx_pid,
   output logic       tx_valid,
   output logic [7:0] tx_data,
   output logic       tx_last,
   input  logic       tx_ready,
   input  logic       rx_hs_valid,
   input  logic [3:0] rx_hs_pid,
   output logic       busy,
   output logic       stat_ack,
   output logic       stat_timeout,
   output logic       stat_drop
);

   localparam logic [3:0] c_PID_DATA0 = 4'h3;
   localparam logic [3:0] c_PID_DATA1 = 4'hB;
   localparam logic [3:0] c_PID_NAK   = 4'hA;
   localparam logic [3:0] c_PID_ACK   = 4'h2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CHECK   = 3'd1,
      ST_NAK     = 3'd2,
      ST_PID     = 3'd3,
      ST_DATA    = 3'd4,
      ST_HS_WAIT = 3'd5,
      ST_RELEASE = 3'd6
   } state_t;

   state_t     state_q, state_d;
   logic       armed_q;
   logic [3:0] sel_q;
   logic [9:0] len_q;
   logic [8:0] addr_q;
   logic [9:0] iss_q;
   logic [9:0] sent_q;
   logic       pend_q;
   logic [7:0] fifo_q [2];
   logic       wptr_q;
   logic       rptr_q;
   logic [1:0] cnt_q;
   logic [3:0] pid_q;
   logic [9:0] hs_cnt_q;
   logic       tx_start_q;
   logic       tog_act_q;
   logic       ack_q;
   logic       to_q;
   logic       drop_q;

   logic       w_tok;
   logic       w_tok_ok;
   logic       w_zlp;
   logic       w_head;
   logic       w_pop;
   logic       w_last;
   logic       w_issue;
   logic       w_hs_ack;
   logic       w_timeout;
   logic       w_unused;

   // armed_q stays low through the first edge after reset release, so a token
   // arriving in that cycle is discarded.
   assign w_tok     = token_in && armed_q;
   assign w_tok_ok  = w_tok && (token_endp <= MAX_ENDP);
   assign w_zlp     = (len_q == 10'd0);
   assign w_head    = (state_q == ST_DATA) && (cnt_q != 2'd0);
   assign w_pop     = w_head && tx_ready;
   assign w_last    = (sent_q == (len_q - 10'd1));
   assign w_hs_ack  = rx_hs_valid && (rx_hs_pid == c_PID_ACK);
   assign w_timeout = (hs_cnt_q == (HS_TIMEOUT - 10'd1));
   assign w_unused  = data_toggle[1];

   // A read is launched only when the 2-entry holding register will still
   // have room for its data one cycle later, counting the read in flight.
   assign w_issue = ((state_q == ST_PID) && !w_zlp) ||
                    ((state_q == ST_DATA) && (iss_q < len_q) &&
                     (({1'b0, cnt_q} + {2'b00, pend_q}) <= (3'd1 + {2'b00, w_pop})));

   always_ff @(posedge phy_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (w_tok_ok) state_d = ST_CHECK;
         end
         ST_CHECK: begin
            state_d = buf_out_hasdata ? ST_PID : ST_NAK;
         end
         ST_NAK: begin
            if (tx_ready) state_d = ST_IDLE;
         end
         ST_PID: begin
            if (!w_zlp)        state_d = ST_DATA;
            else if (tx_ready) state_d = ST_HS_WAIT;
         end
         ST_DATA: begin
            if (w_pop && w_last) state_d = ST_HS_WAIT;
         end
         ST_HS_WAIT: begin
            if (rx_hs_valid)    state_d = w_hs_ack ? ST_RELEASE : ST_IDLE;
            else if (w_timeout) state_d = ST_IDLE;
         end
         ST_RELEASE: begin
            if (buf_out_arm_ack) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      tx_data  = 8'h00;
      case (state_q)
         ST_NAK: begin
            tx_valid = 1'b1;
            tx_last  = 1'b1;
         end
         ST_PID: begin
            tx_valid = w_zlp;
            tx_last  = w_zlp;
         end
         ST_DATA: begin
            tx_valid = w_head;
            tx_last  = w_head && w_last;
            tx_data  = w_head ? fifo_q[rptr_q] : 8'h00;
         end
         default: ;
      endcase
   end

   assign sel_endp        = sel_q;
   assign buf_out_addr    = addr_q;
   assign buf_out_arm     = (state_q == ST_RELEASE);
   assign busy            = (state_q != ST_IDLE);
   assign tx_pid          = pid_q;
   assign tx_start        = tx_start_q;
   assign data_toggle_act = tog_act_q;
   assign stat_ack        = ack_q;
   assign stat_timeout    = to_q;
   assign stat_drop       = drop_q;

   always_ff @(posedge phy_clk or negedge reset_n) begin
      if (!reset_n) begin
         armed_q    <= 1'b0;
         sel_q      <= 4'd0;
         len_q      <= 10'd0;
         addr_q     <= 9'd0;
         iss_q      <= 10'd0;
         sent_q     <= 10'd0;
         pend_q     <= 1'b0;
         fifo_q[0]  <= 8'h00;
         fifo_q[1]  <= 8'h00;
         wptr_q     <= 1'b0;
         rptr_q     <= 1'b0;
         cnt_q      <= 2'd0;
         pid_q      <= 4'd0;
         hs_cnt_q   <= 10'd0;
         tx_start_q <= 1'b0;
         tog_act_q  <= 1'b0;
         ack_q      <= 1'b0;
         to_q       <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         armed_q    <= 1'b1;
         tx_start_q <= 1'b0;
         tog_act_q  <= 1'b0;
         ack_q      <= 1'b0;
         to_q       <= 1'b0;
         drop_q     <= w_tok && ((state_q != ST_IDLE) || (token_endp > MAX_ENDP));

         if ((state_q == ST_IDLE) && w_tok_ok) sel_q <= token_endp;

         // Read pipeline: address/launch, capture one cycle later, drain on pop.
         pend_q <= w_issue;
         if (w_issue) begin
            iss_q <= iss_q + 10'd1;
            if ((iss_q + 10'd1) < len_q) addr_q <= addr_q + 9'd1;
         end
         if (pend_q) begin
            fifo_q[wptr_q] <= buf_out_q;
            wptr_q         <= ~wptr_q;
         end
         if (w_pop) begin
            rptr_q <= ~rptr_q;
            sent_q <= sent_q + 10'd1;
            if (w_last) addr_q <= 9'd0;
         end
         cnt_q <= cnt_q + {1'b0, pend_q} - {1'b0, w_pop};

         if (state_q == ST_CHECK) begin
            tx_start_q <= 1'b1;
            addr_q     <= 9'd0;
            iss_q      <= 10'd0;
            sent_q     <= 10'd0;
            if (buf_out_hasdata) begin
               len_q <= buf_out_len;
               pid_q <= data_toggle[0] ? c_PID_DATA1 : c_PID_DATA0;
            end else begin
               pid_q <= c_PID_NAK;
            end
         end

         if (state_q == ST_HS_WAIT) begin
            hs_cnt_q <= hs_cnt_q + 10'd1;
            if (rx_hs_valid) begin
               ack_q     <= w_hs_ack;
               tog_act_q <= w_hs_ack;
            end else if (w_timeout) begin
               to_q <= 1'b1;
            end
         end else begin
            hs_cnt_q <= 10'd0;
         end
      end
   end

endmodule
`default_nettype wire
